// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, ExcCode values, the MEM-stage exception
// type and the priority decode that turns it into an ExcCode plus BadVAddr source.
package cp0_regfile_pkg;

  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef struct packed {
    logic Interrupt;
    logic WrongAddressinIF;
    logic ReservedInstruction;
    logic Syscall;
    logic Break;
    logic Overflow;
    logic WrWrongAddressinMEM;
    logic RdWrongAddressinMEM;
    logic Eret;
  } ExceptinPipeType;

  typedef enum logic [1:0] {
    BADV_KEEP = 2'd0,
    BADV_PC   = 2'd1,
    BADV_MEM  = 2'd2
  } badv_src_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] code;
    badv_src_e  badv_src;
  } exc_decode_t;

  // Eret is deliberately excluded: valid means "enter the exception vector".
  function automatic exc_decode_t decode_exc(input ExceptinPipeType e);
    exc_decode_t d;
    d.valid    = 1'b1;
    d.code     = EXC_INT;
    d.badv_src = BADV_KEEP;
    if (e.Interrupt) begin
      d.code = EXC_INT;
    end else if (e.WrongAddressinIF) begin
      d.code     = EXC_ADEL;
      d.badv_src = BADV_PC;
    end else if (e.ReservedInstruction) begin
      d.code = EXC_RI;
    end else if (e.Syscall) begin
      d.code = EXC_SYS;
    end else if (e.Break) begin
      d.code = EXC_BP;
    end else if (e.Overflow) begin
      d.code = EXC_OV;
    end else if (e.WrWrongAddressinMEM) begin
      d.code     = EXC_ADES;
      d.badv_src = BADV_MEM;
    end else if (e.RdWrongAddressinMEM) begin
      d.code     = EXC_ADEL;
      d.badv_src = BADV_MEM;
    end else begin
      d.valid = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// Bundle between the pipeline and CP0: exception commit inputs, MTC0/MFC0 access,
// and the Status/Cause/EPC/redirect feedback. The CP0 block uses the slave modport.
interface cp0_regfile_if;

  logic [5:0]                        Int_i;
  cp0_regfile_pkg::ExceptinPipeType  ExceptType_i;
  logic                              IsDelaySlot_i;
  logic [31:0]                       CurrentPC_i;
  logic [31:0]                       MemAddr_i;
  // MTC0 is a single-cycle write strobe with no back-pressure: a write is taken on every
  // edge where CP0RegWr_i is high; MFC0 data is valid in the same cycle as the address.
  logic                              CP0RegWr_i;
  logic [4:0]                        CP0RegWrAddr_i;
  logic [31:0]                       CP0RegWrData_i;
  logic [4:0]                        CP0RegRdAddr_i;
  logic [31:0]                       CP0RdData_o;
  logic [31:0]                       CP0Status_o;
  logic [31:0]                       CP0Cause_o;
  logic [31:0]                       CP0Epc_o;
  logic                              ExcRedirect_o;
  logic [31:0]                       ExcTargetPC_o;
  logic                              TimerInt_o;

  modport slave (
    input  Int_i, ExceptType_i, IsDelaySlot_i, CurrentPC_i, MemAddr_i,
    input  CP0RegWr_i, CP0RegWrAddr_i, CP0RegWrData_i, CP0RegRdAddr_i,
    output CP0RdData_o, CP0Status_o, CP0Cause_o, CP0Epc_o,
    output ExcRedirect_o, ExcTargetPC_o, TimerInt_o
  );

  modport master (
    output Int_i, ExceptType_i, IsDelaySlot_i, CurrentPC_i, MemAddr_i,
    output CP0RegWr_i, CP0RegWrAddr_i, CP0RegWrData_i, CP0RegRdAddr_i,
    input  CP0RdData_o, CP0Status_o, CP0Cause_o, CP0Epc_o,
    input  ExcRedirect_o, ExcTargetPC_o, TimerInt_o
  );

endinterface

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer: prescaled Count, Compare, and the sticky timer interrupt flag.
module cp0_regfile_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int unsigned   PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          ti_q, ti_d;
  logic          tick;

  always_comb begin
    tick      = (presc_q == PRESC_LAST);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we_i) begin
      count_d = wr_data_i;
      presc_d = '0;
    end else if (tick) begin
      count_d = count_q + 32'd1;
      if (count_d == compare_q) ti_d = 1'b1;
    end
    // A Compare write acknowledges the interrupt, even against a same-cycle match.
    if (compare_we_i) begin
      compare_d = wr_data_i;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file and exception commit point: Status/Cause/EPC/BadVAddr update,
// MFC0/MTC0 access, timer, and the fetch redirect for exceptions and ERET.
module cp0_regfile #(
  parameter logic [31:0] EXC_VECTOR = cp0_regfile_pkg::EXC_VECTOR_DEFAULT,
  parameter int unsigned COUNT_DIV  = 2
) (
  input logic          clk,
  input logic          rst,
  cp0_regfile_if.slave bus
);

  import cp0_regfile_pkg::*;

  logic [31:0] badv_q, badv_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [5:0]  int_q;

  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [31:0] wdata, epc_fwd;
  logic [31:0] count, compare, status, cause;
  logic        ti, is_eret;
  exc_decode_t exc;

  assign wdata      = bus.CP0RegWrData_i;
  assign wr_count   = bus.CP0RegWr_i && (bus.CP0RegWrAddr_i == CP0_REG_COUNT);
  assign wr_compare = bus.CP0RegWr_i && (bus.CP0RegWrAddr_i == CP0_REG_COMPARE);
  assign wr_status  = bus.CP0RegWr_i && (bus.CP0RegWrAddr_i == CP0_REG_STATUS);
  assign wr_cause   = bus.CP0RegWr_i && (bus.CP0RegWrAddr_i == CP0_REG_CAUSE);
  assign wr_epc     = bus.CP0RegWr_i && (bus.CP0RegWrAddr_i == CP0_REG_EPC);

  assign exc     = decode_exc(bus.ExceptType_i);
  assign is_eret = bus.ExceptType_i.Eret && !exc.valid;
  // The MTC0 in WB is older than the ERET in MEM, so ERET must see its EPC value.
  assign epc_fwd = wr_epc ? wdata : epc_q;

  cp0_regfile_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .count_we_i  (wr_count),
    .compare_we_i(wr_compare),
    .wr_data_i   (wdata),
    .count_o     (count),
    .compare_o   (compare),
    .ti_o        (ti)
  );

  always_comb begin
    badv_d     = badv_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exc_code_d = exc_code_q;
    if (wr_status) begin
      im_d  = wdata[15:8];
      exl_d = wdata[1];
      ie_d  = wdata[0];
    end
    if (wr_cause) ip_sw_d = wdata[9:8];
    if (wr_epc)   epc_d   = wdata;
    if (exc.valid) begin
      exc_code_d = exc.code;
      exl_d      = 1'b1;
      // Nested exceptions keep the EPC/BD of the outermost one.
      if (!exl_q) begin
        epc_d = bus.IsDelaySlot_i ? bus.CurrentPC_i - 32'd4 : bus.CurrentPC_i;
        bd_d  = bus.IsDelaySlot_i;
      end
      case (exc.badv_src)
        BADV_PC:  badv_d = bus.CurrentPC_i;
        BADV_MEM: badv_d = bus.MemAddr_i;
        default:  badv_d = badv_q;
      endcase
    end else if (is_eret) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badv_q     <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_sw_q    <= '0;
      exc_code_q <= '0;
      int_q      <= '0;
    end else begin
      badv_q     <= badv_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_sw_q    <= ip_sw_d;
      exc_code_q <= exc_code_d;
      int_q      <= bus.Int_i;
    end
  end

  assign status = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause  = {bd_q, ti, 14'b0, int_q[5] | ti, int_q[4:0], ip_sw_q, 1'b0, exc_code_q, 2'b00};

  always_comb begin
    case (bus.CP0RegRdAddr_i)
      CP0_REG_BADVADDR: bus.CP0RdData_o = badv_q;
      CP0_REG_COUNT:    bus.CP0RdData_o = count;
      CP0_REG_COMPARE:  bus.CP0RdData_o = compare;
      CP0_REG_STATUS:   bus.CP0RdData_o = status;
      CP0_REG_CAUSE:    bus.CP0RdData_o = cause;
      CP0_REG_EPC:      bus.CP0RdData_o = epc_q;
      default:          bus.CP0RdData_o = 32'd0;
    endcase
  end

  assign bus.CP0Status_o   = status;
  assign bus.CP0Cause_o    = cause;
  assign bus.CP0Epc_o      = epc_q;
  assign bus.TimerInt_o    = ti;
  assign bus.ExcRedirect_o = exc.valid | is_eret;
  assign bus.ExcTargetPC_o = exc.valid ? EXC_VECTOR : (is_eret ? epc_fwd : 32'd0);

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed scenarios followed by randomized traffic, every
// cycle compared against a register-word model built from the architectural rules.
module tb_cp0_regfile;

  import cp0_regfile_pkg::*;

  localparam int unsigned DIV = 2;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic clk = 1'b0;
  logic rst;
  int   checks;
  int   errors;

  always #10 clk = ~clk;

  cp0_regfile_if cp0_bus ();

  cp0_regfile #(.EXC_VECTOR(VEC), .COUNT_DIV(DIV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(cp0_bus.slave)
  );

  // Reference model: whole architectural register words.
  logic [31:0] m_badv, m_count, m_compare, m_status, m_cause, m_epc;
  logic [5:0]  m_int;
  int          m_phase;

  logic [4:0] reg_tab [6] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_badv = 0; m_count = 0; m_compare = 0; m_status = 32'h0040_0000;
    m_cause = 0; m_epc = 0; m_int = 0; m_phase = 0;
  endtask

  function automatic logic [31:0] exp_cause();
    logic ti;
    ti = m_cause[30];
    return m_cause | ({31'b0, m_int[5] | ti} << 15) | ({27'b0, m_int[4:0]} << 10);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return exp_cause();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0]     old_compare;
    logic            old_exl, wr;
    logic [4:0]      addr;
    logic [31:0]     data, pc;
    ExceptinPipeType t;
    int              code, bsrc;
    old_compare = m_compare;
    old_exl     = m_status[1];
    wr   = cp0_bus.CP0RegWr_i;
    addr = cp0_bus.CP0RegWrAddr_i;
    data = cp0_bus.CP0RegWrData_i;
    pc   = cp0_bus.CurrentPC_i;
    t    = cp0_bus.ExceptType_i;
    if (wr && addr == 5'd9) begin
      m_count = data;
      m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase == int'(DIV)) begin
        m_phase = 0;
        m_count = m_count + 1;
        if (m_count == old_compare) m_cause[30] = 1'b1;
      end
    end
    if (wr && addr == 5'd11) begin
      m_compare   = data;
      m_cause[30] = 1'b0;
    end
    if (wr && addr == 5'd12) m_status = (m_status & ~32'h0000_FF03) | (data & 32'h0000_FF03);
    if (wr && addr == 5'd13) m_cause  = (m_cause & ~32'h0000_0300) | (data & 32'h0000_0300);
    if (wr && addr == 5'd14) m_epc    = data;
    code = -1;
    bsrc = 0;
    if (t.Interrupt)                begin code = 0;  end
    else if (t.WrongAddressinIF)    begin code = 4;  bsrc = 1; end
    else if (t.ReservedInstruction) begin code = 10; end
    else if (t.Syscall)             begin code = 8;  end
    else if (t.Break)               begin code = 9;  end
    else if (t.Overflow)            begin code = 12; end
    else if (t.WrWrongAddressinMEM) begin code = 5;  bsrc = 2; end
    else if (t.RdWrongAddressinMEM) begin code = 4;  bsrc = 2; end
    if (code >= 0) begin
      m_cause[6:2] = code[4:0];
      m_status[1]  = 1'b1;
      if (!old_exl) begin
        m_epc       = cp0_bus.IsDelaySlot_i ? pc - 32'd4 : pc;
        m_cause[31] = cp0_bus.IsDelaySlot_i;
      end
      if (bsrc == 1) m_badv = pc;
      if (bsrc == 2) m_badv = cp0_bus.MemAddr_i;
    end else if (t.Eret) begin
      m_status[1] = 1'b0;
    end
    m_int = cp0_bus.Int_i;
  endtask

  task automatic cycle();
    ExceptinPipeType t;
    logic            exc, eret;
    logic [31:0]     tgt;
    @(negedge clk);
    t      = cp0_bus.ExceptType_i;
    eret   = t.Eret;
    t.Eret = 1'b0;
    exc    = (t != '0);
    if (exc) tgt = VEC;
    else if (eret) tgt = (cp0_bus.CP0RegWr_i && cp0_bus.CP0RegWrAddr_i == 5'd14) ?
                         cp0_bus.CP0RegWrData_i : m_epc;
    else tgt = 32'd0;
    check("redirect", {31'b0, cp0_bus.ExcRedirect_o}, {31'b0, exc | eret});
    check("target",   cp0_bus.ExcTargetPC_o, tgt);
    check("status",   cp0_bus.CP0Status_o, m_status);
    check("cause",    cp0_bus.CP0Cause_o, exp_cause());
    check("epc",      cp0_bus.CP0Epc_o, m_epc);
    check("timerint", {31'b0, cp0_bus.TimerInt_o}, {31'b0, m_cause[30]});
    check("rddata",   cp0_bus.CP0RdData_o, exp_read(cp0_bus.CP0RegRdAddr_i));
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic idle();
    cp0_bus.Int_i          = '0;
    cp0_bus.ExceptType_i   = '0;
    cp0_bus.IsDelaySlot_i  = 1'b0;
    cp0_bus.CurrentPC_i    = '0;
    cp0_bus.MemAddr_i      = '0;
    cp0_bus.CP0RegWr_i     = 1'b0;
    cp0_bus.CP0RegWrAddr_i = '0;
    cp0_bus.CP0RegWrData_i = '0;
    cp0_bus.CP0RegRdAddr_i = '0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_bus.CP0RegWr_i     = 1'b1;
    cp0_bus.CP0RegWrAddr_i = a;
    cp0_bus.CP0RegWrData_i = d;
  endtask

  task automatic read_const(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cp0_bus.CP0RegRdAddr_i = a;
    #1;
    check(tag, cp0_bus.CP0RdData_o, exp);
  endtask

  initial begin
    logic [8:0] ev;
    checks = 0;
    errors = 0;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    read_const("rst_badv",    5'd8,  32'h0);
    read_const("rst_count",   5'd9,  32'h0);
    read_const("rst_compare", 5'd11, 32'h0);
    read_const("rst_status",  5'd12, 32'h0040_0000);
    read_const("rst_cause",   5'd13, 32'h0);
    read_const("rst_epc",     5'd14, 32'h0);
    check("rst_redirect", {31'b0, cp0_bus.ExcRedirect_o}, 32'h0);
    check("rst_ti",       {31'b0, cp0_bus.TimerInt_o},    32'h0);
    rst = 1'b0;
    cycle();

    // Overflow in a delay slot, EXL clear.
    cp0_bus.ExceptType_i.Overflow = 1'b1;
    cp0_bus.IsDelaySlot_i = 1'b1;
    cp0_bus.CurrentPC_i   = 32'h8000_1004;
    #1;
    check("ov_redirect", {31'b0, cp0_bus.ExcRedirect_o}, 32'h1);
    check("ov_target",   cp0_bus.ExcTargetPC_o, 32'hBFC0_0380);
    cycle();
    idle();
    #1;
    check("ov_epc",  cp0_bus.CP0Epc_o, 32'h8000_1000);
    check("ov_bd",   {31'b0, cp0_bus.CP0Cause_o[31]}, 32'h1);
    check("ov_code", {27'b0, cp0_bus.CP0Cause_o[6:2]}, 32'h0C);
    check("ov_exl",  {31'b0, cp0_bus.CP0Status_o[1]}, 32'h1);

    // Nested Syscall keeps the first EPC.
    cp0_bus.ExceptType_i.Syscall = 1'b1;
    cp0_bus.CurrentPC_i = 32'h8000_2000;
    cycle();
    idle();
    #1;
    check("sys_epc",  cp0_bus.CP0Epc_o, 32'h8000_1000);
    check("sys_code", {27'b0, cp0_bus.CP0Cause_o[6:2]}, 32'h08);

    // ERET with a same-cycle MTC0 EPC.
    mtc0(5'd14, 32'h8000_3000);
    cp0_bus.ExceptType_i.Eret = 1'b1;
    #1;
    check("eret_target", cp0_bus.ExcTargetPC_o, 32'h8000_3000);
    cycle();
    idle();
    #1;
    check("eret_exl", {31'b0, cp0_bus.CP0Status_o[1]}, 32'h0);

    // Timer: Compare=5, Count=0, TI after 10 cycles.
    mtc0(5'd11, 32'd5);
    cycle();
    mtc0(5'd9, 32'd0);
    cycle();
    idle();
    repeat (9) cycle();
    check("ti_early", {31'b0, cp0_bus.TimerInt_o}, 32'h0);
    cycle();
    check("ti_set",   {31'b0, cp0_bus.TimerInt_o}, 32'h1);
    check("ti_ip7",   {31'b0, cp0_bus.CP0Cause_o[15]}, 32'h1);
    read_const("ti_count", 5'd9, 32'd5);
    mtc0(5'd11, 32'd5);
    cycle();
    idle();
    #1;
    check("ti_clear", {31'b0, cp0_bus.TimerInt_o}, 32'h0);

    // Load address error in MEM.
    cp0_bus.ExceptType_i.RdWrongAddressinMEM = 1'b1;
    cp0_bus.MemAddr_i   = 32'h0000_0003;
    cp0_bus.CurrentPC_i = 32'h8000_4000;
    cycle();
    idle();
    read_const("adel_badv", 5'd8, 32'h3);
    check("adel_code", {27'b0, cp0_bus.CP0Cause_o[6:2]}, 32'h04);

    // Count wrap.
    mtc0(5'd9, 32'hFFFF_FFFF);
    cycle();
    idle();
    cycle();
    read_const("wrap_pre", 5'd9, 32'hFFFF_FFFF);
    cycle();
    read_const("wrap_post", 5'd9, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      idle();
      cp0_bus.Int_i = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 9))
        6, 7:    ev = 9'b1 << $urandom_range(0, 8);
        8, 9:    ev = 9'($urandom_range(1, 511));
        default: ev = '0;
      endcase
      cp0_bus.ExceptType_i  = ev;
      cp0_bus.IsDelaySlot_i = 1'($urandom_range(0, 1));
      cp0_bus.CurrentPC_i   = $urandom;
      cp0_bus.MemAddr_i     = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        cp0_bus.CP0RegWr_i     = 1'b1;
        cp0_bus.CP0RegWrAddr_i = ($urandom_range(0, 6) == 6) ? 5'($urandom_range(0, 31))
                                                              : reg_tab[$urandom_range(0, 5)];
        cp0_bus.CP0RegWrData_i = (cp0_bus.CP0RegWrAddr_i == 5'd11) ?
                                 m_count + 32'($urandom_range(0, 6)) : $urandom;
      end
      cp0_bus.CP0RegRdAddr_i = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                            : reg_tab[$urandom_range(0, 5)];
      cycle();
    end

    // Reset mid-operation with TI pending and an MTC0 on the same edge.
    idle();
    mtc0(5'd11, 32'd1);
    cycle();
    mtc0(5'd9, 32'd0);
    cycle();
    idle();
    cycle();
    cycle();
    check("pre_rst_ti", {31'b0, cp0_bus.TimerInt_o}, 32'h1);
    rst = 1'b1;
    mtc0(5'd12, 32'h0000_FF03);
    cycle();
    rst = 1'b0;
    idle();
    #1;
    check("mid_rst_ti", {31'b0, cp0_bus.TimerInt_o}, 32'h0);
    read_const("mid_rst_status",  5'd12, 32'h0040_0000);
    read_const("mid_rst_count",   5'd9,  32'h0);
    read_const("mid_rst_compare", 5'd11, 32'h0);
    read_const("mid_rst_cause",   5'd13, 32'h0);
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
